// File: rtl/des_scan_sequencer_pkg.sv
// Shared definitions for the DES scan-chain sequencer: command op codes,
// FSM state encodings and default geometry of the attached core.
package des_scan_sequencer_pkg;

    localparam int CHAIN_LEN_DEF   = 132;
    localparam int RUN_TIMEOUT_DEF = 31;

    typedef enum logic [1:0] {
        OP_RUN  = 2'd0,
        OP_STEP = 2'd1,
        OP_SCAN = 2'd2,
        OP_LOAD = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_RUN_WAIT  = 3'd2,
        ST_STEP_WAIT = 3'd3,
        ST_SHIFT     = 3'd4,
        ST_DONE      = 3'd5
    } state_e;

endpackage

// File: rtl/des_scan_sequencer_shifter.sv
// Scan-chain datapath: load shift register, capture shift register, shift
// counter and the rotate/load mux feeding the core's scan_in.
module des_scan_shifter
    import des_scan_sequencer_pkg::*;
#(
    parameter int CHAIN_LEN = CHAIN_LEN_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_en,
    input  logic [CHAIN_LEN-1:0] load_vec,
    input  logic                 start_shift,
    input  logic                 shift_en,
    input  logic                 use_load,
    input  logic                 scan_out,
    output logic                 scan_in,
    output logic [CHAIN_LEN-1:0] capture_vec,
    output logic                 shift_done
);

    localparam int CW = $clog2(CHAIN_LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);

    logic [CHAIN_LEN-1:0] load_sh_q, load_sh_d;
    logic [CHAIN_LEN-1:0] cap_sh_q, cap_sh_d;
    logic [CHAIN_LEN-1:0] capture_q, capture_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    assign shift_done  = shift_en && (cnt_q == LAST);
    assign scan_in     = shift_en & (use_load ? load_sh_q[0] : scan_out);
    assign capture_vec = capture_q;

    always_comb begin
        load_sh_d = load_sh_q;
        cap_sh_d  = cap_sh_q;
        capture_d = capture_q;
        cnt_d     = cnt_q;
        if (start_shift) cnt_d = '0;
        if (load_en) load_sh_d = load_vec;
        if (shift_en) begin
            cap_sh_d  = {scan_out, cap_sh_q[CHAIN_LEN-1:1]};
            load_sh_d = {1'b0, load_sh_q[CHAIN_LEN-1:1]};
            cnt_d     = cnt_q + CW'(1);
            // Publish only the complete snapshot, never a partially shifted one.
            if (shift_done) capture_d = {scan_out, cap_sh_q[CHAIN_LEN-1:1]};
        end
    end

    // NOTE: these wide registers are ordinary flops, not a RAM, so they take
    // the reset like everything else and capture_vec is never X after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_sh_q <= '0;
            cap_sh_q  <= '0;
            capture_q <= '0;
            cnt_q     <= '0;
        end else begin
            load_sh_q <= load_sh_d;
            cap_sh_q  <= cap_sh_d;
            capture_q <= capture_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: rtl/des_scan_sequencer.sv
// Command-driven sequencer for one fixed-key DES scan-chain core: starts
// runs, steps the core a fixed number of cycles, snapshots and loads the chain.
module des_scan_sequencer
    import des_scan_sequencer_pkg::*;
#(
    parameter int CHAIN_LEN   = CHAIN_LEN_DEF,
    parameter int RUN_TIMEOUT = RUN_TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic                 cmd_encrypt,
    input  logic [7:0]           cmd_cycles,
    input  logic [CHAIN_LEN-1:0] load_vec,
    output logic [CHAIN_LEN-1:0] capture_vec,
    output logic                 done,
    output logic                 error,
    output logic                 core_start,
    output logic                 core_encrypt_ndecrypt,
    input  logic                 core_busy,
    output logic                 core_scan_enable,
    output logic                 core_scan_in,
    input  logic                 core_scan_out
);

    localparam int TW = $clog2(RUN_TIMEOUT + 1);

    state_e        state_q, state_d;
    op_e           op_q, op_d;
    op_e           cmd_op_e;
    logic          enc_q, enc_d;
    logic          error_q, error_d;
    logic [7:0]    step_cnt_q, step_cnt_d;
    logic [TW-1:0] run_cnt_q, run_cnt_d;
    logic          accept, start_shift, load_en, shift_done;

    assign cmd_op_e              = op_e'(cmd_op);
    assign cmd_ready             = (state_q == ST_IDLE);
    assign accept                = cmd_valid & cmd_ready;
    assign core_start            = (state_q == ST_START);
    assign core_scan_enable      = (state_q == ST_SHIFT);
    assign done                  = (state_q == ST_DONE);
    assign error                 = error_q;
    assign core_encrypt_ndecrypt = enc_q;

    // NOTE: every signal written here gets its default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        enc_d       = enc_q;
        error_d     = error_q;
        step_cnt_d  = step_cnt_q;
        run_cnt_d   = run_cnt_q;
        start_shift = 1'b0;
        load_en     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d       = cmd_op_e;
                    error_d    = 1'b0;
                    step_cnt_d = cmd_cycles;
                    run_cnt_d  = '0;
                    case (cmd_op_e)
                        OP_RUN, OP_STEP: begin
                            enc_d   = cmd_encrypt;
                            state_d = ST_START;
                        end
                        OP_LOAD: begin
                            load_en     = 1'b1;
                            start_shift = 1'b1;
                            state_d     = ST_SHIFT;
                        end
                        default: begin
                            start_shift = 1'b1;
                            state_d     = ST_SHIFT;
                        end
                    endcase
                end
            end
            ST_START: begin
                if (op_q == OP_RUN) begin
                    state_d = ST_RUN_WAIT;
                end else if (step_cnt_q == 8'd0) begin
                    start_shift = 1'b1;
                    state_d     = ST_SHIFT;
                end else begin
                    state_d = ST_STEP_WAIT;
                end
            end
            ST_RUN_WAIT: begin
                // The core may not have raised busy yet on the first cycle.
                if (run_cnt_q == '0) begin
                    run_cnt_d = TW'(1);
                end else if (!core_busy) begin
                    state_d = ST_DONE;
                end else if (run_cnt_q == TW'(RUN_TIMEOUT)) begin
                    error_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    run_cnt_d = run_cnt_q + TW'(1);
                end
            end
            ST_STEP_WAIT: begin
                if (step_cnt_q == 8'd1) begin
                    start_shift = 1'b1;
                    state_d     = ST_SHIFT;
                end else begin
                    step_cnt_d = step_cnt_q - 8'd1;
                end
            end
            ST_SHIFT: begin
                if (shift_done) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_RUN;
            enc_q      <= 1'b0;
            error_q    <= 1'b0;
            step_cnt_q <= '0;
            run_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            enc_q      <= enc_d;
            error_q    <= error_d;
            step_cnt_q <= step_cnt_d;
            run_cnt_q  <= run_cnt_d;
        end
    end

    des_scan_shifter #(
        .CHAIN_LEN(CHAIN_LEN)
    ) u_shifter (
        .clk         (clk),
        .rst         (rst),
        .load_en     (load_en),
        .load_vec    (load_vec),
        .start_shift (start_shift),
        .shift_en    (core_scan_enable),
        .use_load    (op_q == OP_LOAD),
        .scan_out    (core_scan_out),
        .scan_in     (core_scan_in),
        .capture_vec (capture_vec),
        .shift_done  (shift_done)
    );

endmodule

// File: tb/tb_des_scan_sequencer.sv
// Self-checking bench for des_scan_sequencer: a behavioural scan-chain core
// plus a chain-contents model that predicts every snapshot.
module tb_des_scan_sequencer;

    localparam int CL       = 132;
    localparam int RT       = 31;
    localparam int BUSY_LEN = 17;
    localparam int BUDGET   = 400;

    localparam logic [1:0] OP_RUN  = 2'd0;
    localparam logic [1:0] OP_STEP = 2'd1;
    localparam logic [1:0] OP_SCAN = 2'd2;
    localparam logic [1:0] OP_LOAD = 2'd3;

    localparam logic [CL-1:0] A5_LIT = {4'h5, {16{8'hA5}}};
    localparam logic [CL-1:0] V2     = {4'h1, 128'h01234567_89ABCDEF_FEDCBA98_76543210};
    localparam logic [CL-1:0] V3     = {4'hC, 128'hDEADBEEF_0BADF00D_CAFEF00D_12345678};
    localparam logic [CL-1:0] KEY    = {4'h9, 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0};

    logic          clk;
    logic          rst;
    logic          cmd_valid, cmd_ready;
    logic [1:0]    cmd_op;
    logic          cmd_encrypt;
    logic [7:0]    cmd_cycles;
    logic [CL-1:0] load_vec, capture_vec;
    logic          done, error;
    logic          core_start, core_encrypt_ndecrypt, core_busy;
    logic          core_scan_enable, core_scan_in, core_scan_out;

    int checks   = 0;
    int failures = 0;

    des_scan_sequencer #(
        .CHAIN_LEN  (CL),
        .RUN_TIMEOUT(RT)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .cmd_valid            (cmd_valid),
        .cmd_ready            (cmd_ready),
        .cmd_op               (cmd_op),
        .cmd_encrypt          (cmd_encrypt),
        .cmd_cycles           (cmd_cycles),
        .load_vec             (load_vec),
        .capture_vec          (capture_vec),
        .done                 (done),
        .error                (error),
        .core_start           (core_start),
        .core_encrypt_ndecrypt(core_encrypt_ndecrypt),
        .core_busy            (core_busy),
        .core_scan_enable     (core_scan_enable),
        .core_scan_in         (core_scan_in),
        .core_scan_out        (core_scan_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [CL-1:0] act, input logic [CL-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One "round" of the stand-in core: rotate left by 3 and mix in a key.
    function automatic logic [CL-1:0] core_f(input logic [CL-1:0] x);
        return {x[CL-4:0], x[CL-1:CL-3]} ^ KEY;
    endfunction

    function automatic logic [CL-1:0] f_pow(input logic [CL-1:0] x, input int n);
        logic [CL-1:0] y;
        y = x;
        for (int i = 0; i < n; i++) y = core_f(y);
        return y;
    endfunction

    // Stand-in core: scan shifts right with new bit at the top; a start makes it
    // busy for BUSY_LEN cycles, one round each; scan_enable aborts a run.
    logic [CL-1:0] chain  = '0;
    logic          busy_q = 1'b0;
    int            rem    = 0;
    bit            stuck  = 1'b0;

    assign core_scan_out = chain[0];
    assign core_busy     = busy_q | stuck;

    always @(posedge clk) begin
        if (core_scan_enable) begin
            chain  <= {core_scan_in, chain[CL-1:1]};
            busy_q <= 1'b0;
        end else if (core_start) begin
            busy_q <= 1'b1;
            rem    <= BUSY_LEN;
        end else if (busy_q) begin
            chain <= core_f(chain);
            rem   <= rem - 1;
            if (rem == 1) busy_q <= 1'b0;
        end
    end

    // Expectations shared with the compare process.
    logic          exp_enc       = 1'b0;
    bit            exp_cap_valid = 1'b0;
    logic [CL-1:0] exp_capture   = '0;
    logic [CL-1:0] chain_model   = '0;

    initial begin : compare
        logic [CL-1:0] prev_cap;
        bit            prev_ok;
        prev_ok  = 1'b0;
        prev_cap = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                prev_ok = 1'b0;
            end else begin
                check("start_scan_exclusive", {131'd0, core_start & core_scan_enable}, '0);
                check("encrypt_hold", {131'd0, core_encrypt_ndecrypt}, {131'd0, exp_enc});
                if (done && exp_cap_valid)
                    check("capture_at_done", capture_vec, exp_capture);
                else if (!done && prev_ok)
                    check("capture_stable", capture_vec, prev_cap);
                prev_cap = capture_vec;
                prev_ok  = 1'b1;
            end
        end
    end

    int   r_start_cnt, r_start_at, r_first_en, r_en_cnt, r_fall_at, r_done_at, r_ready_seen;
    logic r_err_first, r_err_done;

    task automatic do_cmd(input logic [1:0] op, input logic enc, input logic [7:0] cyc,
                          input logic [CL-1:0] vec, input bit cap_valid,
                          input logic [CL-1:0] cap_exp, input bit hold);
        bit seen_busy;
        seen_busy = 1'b0;
        @(negedge clk);
        check("ready_before_cmd", {131'd0, cmd_ready}, 1);
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_encrypt = enc;
        cmd_cycles  = cyc;
        load_vec    = vec;
        exp_cap_valid = cap_valid;
        exp_capture   = cap_exp;
        if (op == OP_RUN || op == OP_STEP) exp_enc = enc;
        r_start_cnt = 0; r_start_at = -1; r_first_en = -1; r_en_cnt = 0;
        r_fall_at = -1; r_done_at = -1; r_ready_seen = 0;
        r_err_first = 1'bx; r_err_done = 1'bx;
        for (int k = 1; k <= BUDGET; k++) begin
            @(negedge clk);
            if (!hold) cmd_valid = 1'b0;
            if (k == 1) r_err_first = error;
            if (cmd_ready) r_ready_seen++;
            if (core_start) begin
                r_start_cnt++;
                if (r_start_at < 0) r_start_at = k;
            end
            if (core_busy) seen_busy = 1'b1;
            else if (seen_busy && r_fall_at < 0) r_fall_at = k;
            if (core_scan_enable) begin
                r_en_cnt++;
                if (r_first_en < 0) r_first_en = k;
            end
            if (done) begin
                r_done_at  = k;
                r_err_done = error;
                break;
            end
        end
        cmd_valid = 1'b0;
        check("done_within_budget", {131'd0, done}, 1);
        check("no_ready_while_busy", r_ready_seen, 0);
    endtask

    task automatic check_shift_cmd(input string tag);
        check({tag, "_starts"}, r_start_cnt, 0);
        check({tag, "_first_enable"}, r_first_en, 1);
        check({tag, "_enable_cycles"}, r_en_cnt, CL);
        check({tag, "_done_cycle"}, r_done_at, CL + 1);
    endtask

    task automatic check_run_ok(input string tag);
        check({tag, "_starts"}, r_start_cnt, 1);
        check({tag, "_start_cycle"}, r_start_at, 1);
        check({tag, "_busy_fall"}, r_fall_at, 2 + BUSY_LEN);
        check({tag, "_done_after_fall"}, r_done_at, r_fall_at + 1);
        check({tag, "_no_enable"}, r_en_cnt, 0);
        check({tag, "_error"}, {131'd0, r_err_done}, 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int en_seen;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = OP_RUN; cmd_encrypt = 1'b0;
        cmd_cycles = 8'd0; load_vec = '0;
        repeat (3) @(negedge clk);

        check("reset_cmd_ready", {131'd0, cmd_ready}, 1);
        check("reset_done", {131'd0, done}, 0);
        check("reset_error", {131'd0, error}, 0);
        check("reset_start", {131'd0, core_start}, 0);
        check("reset_scan_enable", {131'd0, core_scan_enable}, 0);
        check("reset_scan_in", {131'd0, core_scan_in}, 0);
        check("reset_encrypt", {131'd0, core_encrypt_ndecrypt}, 0);
        check("reset_capture", capture_vec, '0);
        rst = 1'b0;

        // Reset in the 40th shift cycle of a SCAN.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_SCAN; exp_cap_valid = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        en_seen = 0;
        for (int k = 0; k < 100; k++) begin
            if (core_scan_enable) en_seen++;
            if (en_seen == 40) break;
            @(negedge clk);
        end
        check("enable_cycles_before_reset", en_seen, 40);
        rst = 1'b1;
        @(negedge clk);
        check("midreset_scan_enable", {131'd0, core_scan_enable}, 0);
        check("midreset_cmd_ready", {131'd0, cmd_ready}, 1);
        check("midreset_done", {131'd0, done}, 0);
        check("midreset_error", {131'd0, error}, 0);
        rst = 1'b0;

        // LOAD then SCAN returns the loaded pattern, twice.
        do_cmd(OP_LOAD, 1'b0, 8'd0, A5_LIT, 1'b0, '0, 1'b0);
        check_shift_cmd("load_a5");
        chain_model = A5_LIT;
        do_cmd(OP_SCAN, 1'b0, 8'd0, '0, 1'b1, chain_model, 1'b0);
        check_shift_cmd("scan_a5_1");
        check("scan_a5_1_literal", capture_vec, {4'h5, {16{8'hA5}}});
        do_cmd(OP_SCAN, 1'b0, 8'd0, '0, 1'b1, chain_model, 1'b0);
        check("scan_a5_2_literal", capture_vec, {4'h5, {16{8'hA5}}});
        do_cmd(OP_LOAD, 1'b0, 8'd0, V2, 1'b1, chain_model, 1'b0);
        chain_model = V2;
        do_cmd(OP_SCAN, 1'b0, 8'd0, '0, 1'b1, chain_model, 1'b0);
        check("scan_v2", capture_vec, V2);

        // RUN encrypt with a 17-cycle busy core, then read the result.
        do_cmd(OP_RUN, 1'b1, 8'd0, '0, 1'b0, '0, 1'b0);
        check_run_ok("run_enc");
        chain_model = f_pow(chain_model, BUSY_LEN);
        do_cmd(OP_SCAN, 1'b0, 8'd0, '0, 1'b1, chain_model, 1'b0);
        check("scan_after_run", capture_vec, chain_model);

        // RUN with busy stuck high: timeout, sticky error, cleared by next accept.
        stuck = 1'b1;
        do_cmd(OP_RUN, 1'b0, 8'd0, '0, 1'b0, '0, 1'b0);
        check("timeout_done_cycle", r_done_at, RT + 3);
        check("timeout_error", {131'd0, r_err_done}, 1);
        stuck = 1'b0;
        @(negedge clk);
        check("timeout_error_sticky", {131'd0, error}, 1);
        do_cmd(OP_LOAD, 1'b0, 8'd0, V3, 1'b0, '0, 1'b0);
        check("error_cleared_on_accept", {131'd0, r_err_first}, 0);
        chain_model = V3;

        // STEP with zero and five wait cycles.
        do_cmd(OP_STEP, 1'b1, 8'd0, '0, 1'b1, chain_model, 1'b0);
        check("step0_enable_offset", r_first_en - r_start_at, 1);
        check("step0_enable_cycles", r_en_cnt, CL);
        do_cmd(OP_STEP, 1'b1, 8'd5, '0, 1'b1, f_pow(chain_model, 5), 1'b0);
        check("step5_enable_offset", r_first_en - r_start_at, 6);
        check("step5_done_cycle", r_done_at, 7 + CL);
        chain_model = f_pow(chain_model, 5);
        do_cmd(OP_RUN, 1'b0, 8'd0, '0, 1'b0, '0, 1'b0);
        check_run_ok("run_after_step");
        chain_model = f_pow(chain_model, BUSY_LEN);

        // cmd_valid held through a whole command: exactly one accept.
        do_cmd(OP_SCAN, 1'b0, 8'd0, '0, 1'b1, chain_model, 1'b1);
        check_shift_cmd("scan_held_valid");
        @(negedge clk);
        check("held_valid_back_idle", {131'd0, cmd_ready}, 1);
        check("held_valid_no_done", {131'd0, done}, 0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
